int2float_arbiter: RTL and testbench



---
 rtl/int2float_pkg.sv | 29 ++
 rtl/int2float_core.sv | 27 ++
 rtl/int2float_arbiter.sv | 113 +++++++++++
 tb/tb_int2float_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/int2float_pkg.sv
// Shared constants and helpers for the shared int-to-float conversion pipeline.
// Float format: {exp[2:0], mant[3:0]}; exp=0 holds small integers exactly, exp>0 means ({1,mant} << (exp-1)), truncated.
package int2float_pkg;

    localparam int IW           = 11;
    localparam int OW           = 7;
    localparam int NREQ_DEFAULT = 4;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Reference conversion written as iterative normalisation, independent of the priority-encoder core.
    function automatic logic [OW-1:0] golden_int2float(input logic [IW-1:0] x);
        logic [IW-1:0] m;
        logic [2:0]    e;
        m = x;
        if (m < IW'(16)) begin
            return {3'd0, m[3:0]};
        end
        e = 3'd1;
        while (m >= IW'(32)) begin
            m = m >> 1;
            e = e + 3'd1;
        end
        return {e, m[3:0]};
    endfunction

endpackage

// File: rtl/int2float_core.sv
// Combinational 11-bit unsigned integer to 7-bit float converter (truncating).
module int2float_core
    import int2float_pkg::*;
(
    input  logic [IW-1:0] value,
    output logic [OW-1:0] result
);

    logic [3:0] msb;

    always_comb begin
        msb = 4'd0;
        for (int i = 0; i < IW; i++) begin
            if (value[i]) begin
                msb = 4'(i);
            end
        end
        if (value[IW-1:4] == '0) begin
            result = {3'd0, value[3:0]};
        end else begin
            // Keep the four bits just below the leading one; the leading one is implied.
            result[3:0]    = 4'(value >> (msb - 4'd4));
            result[OW-1:4] = 3'(msb - 4'd3);
        end
    end

endmodule

// File: rtl/int2float_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around the single shared converter.
// Stage A registers the granted operand, stage B registers the converted result.
module int2float_arbiter #(
    parameter int NREQ = int2float_pkg::NREQ_DEFAULT,
    parameter int IW   = int2float_pkg::IW,
    parameter int OW   = int2float_pkg::OW,
    parameter int IDW  = int2float_pkg::id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*IW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               res_valid,
    output logic [OW-1:0]      res_data,
    output logic [IDW-1:0]     res_id,
    input  logic               res_ready,
    output logic [15:0]        conv_count
);

    logic [IW-1:0]   operand [NREQ];
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            found;
    logic            a_free;
    logic            b_free;
    logic            accept;
    logic [IDW-1:0]  ptr_next;
    logic [OW-1:0]   conv_result;

    logic            op_valid_reg;
    logic [IW-1:0]   op_data_reg;
    logic [IDW-1:0]  op_id_reg;
    logic [IDW-1:0]  ptr_reg;
    logic            res_valid_reg;
    logic [OW-1:0]   res_data_reg;
    logic [IDW-1:0]  res_id_reg;
    logic [15:0]     conv_count_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign operand[gi] = req_data[gi*IW +: IW];
        end
    endgenerate

    // Search upward from ptr, wrapping, so the last winner drops to lowest priority.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign b_free    = !res_valid_reg || res_ready;
    assign a_free    = !op_valid_reg || b_free;
    assign req_ready = a_free ? grant : '0;
    assign accept    = a_free && found;
    assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    int2float_core u_core (
        .value  (op_data_reg),
        .result (conv_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_reg   <= 1'b0;
            op_data_reg    <= '0;
            op_id_reg      <= '0;
            ptr_reg        <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_id_reg     <= '0;
            conv_count_reg <= '0;
        end else begin
            if (a_free) begin
                op_valid_reg <= accept;
                if (accept) begin
                    op_data_reg <= operand[grant_id];
                    op_id_reg   <= grant_id;
                    ptr_reg     <= ptr_next;
                end
            end
            if (b_free) begin
                res_valid_reg <= op_valid_reg;
                if (op_valid_reg) begin
                    res_data_reg <= conv_result;
                    res_id_reg   <= op_id_reg;
                end
            end
            if (res_valid_reg && res_ready) begin
                conv_count_reg <= conv_count_reg + 16'd1;
            end
        end
    end

    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_id     = res_id_reg;
    assign conv_count = conv_count_reg;

endmodule

// File: tb/tb_int2float_arbiter.sv
// Scoreboard bench: stimulus pushes expected (id, float) per grant; a monitor pops on each output handshake.
module tb_int2float_arbiter;
    import int2float_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [43:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [6:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic [15:0] conv_count;

    typedef struct {
        logic [1:0] id;
        logic [6:0] f;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_cnt = 16'd0;

    int2float_arbiter #(.NREQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic set_data(input int i, input logic [10:0] v);
        req_data[i*11 +: 11] = v;
    endtask

    // One cycle: drive, check grant at negedge, record expected result, advance past posedge.
    task automatic step(input logic [3:0] v, input logic r, input int g, input logic [6:0] ef);
        logic [3:0] exp_rdy;
        req_valid = v;
        res_ready = r;
        exp_rdy   = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        @(negedge clk);
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        if (g >= 0) begin
            sb.push_back('{id: 2'(g), f: ef});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0000, 1'b1, -1, 7'd0);
        end
    endtask

    task automatic reset_pulse();
        rst       = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: count tracking, backpressure stability, and in-order result checking.
    initial begin
        logic       hold_valid;
        logic [6:0] held_data;
        logic [1:0] held_id;
        exp_t       e;
        hold_valid = 1'b0;
        held_data  = '0;
        held_id    = '0;
        forever begin
            @(negedge clk);
            check("conv_count", {16'd0, conv_count}, {16'd0, model_cnt});
            if (rst) begin
                model_cnt  = 16'd0;
                sb.delete();
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    check("bp_valid", {31'd0, res_valid}, 32'd1);
                    check("bp_data", {25'd0, res_data}, {25'd0, held_data});
                    check("bp_id", {30'd0, res_id}, {30'd0, held_id});
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("res_id", {30'd0, res_id}, {30'd0, e.id});
                        check("res_data", {25'd0, res_data}, {25'd0, e.f});
                    end
                    model_cnt = model_cnt + 16'd1;
                end
                hold_valid = res_valid && !res_ready;
                held_data  = res_data;
                held_id    = res_id;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {25'd0, res_data}, 32'd0);
        check("rst_res_id", {30'd0, res_id}, 32'd0);
        check("rst_conv_count", {16'd0, conv_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request from requester 2.
        set_data(2, 11'd0);
        step(4'b0100, 1'b1, 2, 7'h00);
        idle(3);
        check("single_count", {16'd0, conv_count}, 32'd1);

        // All four held valid, full throughput.
        reset_pulse();
        set_data(0, 11'd5);
        set_data(1, 11'd100);
        set_data(2, 11'd1000);
        set_data(3, 11'd2047);
        for (int rep = 0; rep < 2; rep++) begin
            step(4'b1111, 1'b1, 0, 7'h05);
            step(4'b1111, 1'b1, 1, 7'h39);
            step(4'b1111, 1'b1, 2, 7'h6F);
            step(4'b1111, 1'b1, 3, 7'h7F);
        end
        idle(3);

        // Backpressure: five stalled cycles, only two operands get in.
        step(4'b1111, 1'b0, 0, 7'h05);
        step(4'b1111, 1'b0, 1, 7'h39);
        step(4'b1111, 1'b0, -1, 7'h00);
        step(4'b1111, 1'b0, -1, 7'h00);
        step(4'b1111, 1'b0, -1, 7'h00);
        step(4'b1111, 1'b1, 2, 7'h6F);
        step(4'b1111, 1'b1, 3, 7'h7F);
        step(4'b1111, 1'b1, 0, 7'h05);
        step(4'b1111, 1'b1, 1, 7'h39);
        idle(3);

        // Fairness: ptr is 2, requesters 1,2,3 pending.
        set_data(1, 11'd16);
        set_data(2, 11'd31);
        set_data(3, 11'd32);
        step(4'b1110, 1'b1, 2, 7'h1F);
        step(4'b1010, 1'b1, 3, 7'h20);
        step(4'b0010, 1'b1, 1, 7'h10);
        idle(3);

        // Reset with both stages full; stale ptr would be 2.
        step(4'b0110, 1'b0, 2, 7'h1F);
        step(4'b0010, 1'b0, 1, 7'h10);
        reset_pulse();
        set_data(0, 11'd0);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        @(negedge clk);
        check("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("post_rst_count", {16'd0, conv_count}, 32'd0);
        check("post_rst_grant", {28'd0, req_ready}, 32'd1);
        sb.push_back('{id: 2'd0, f: 7'h00});
        @(posedge clk);
        #1;

        // Exhaustive sweep through requester 0 up to 65534 handshakes, then wrap.
        for (int i = 1; i < 65534; i++) begin
            set_data(0, 11'(i % 2048));
            step(4'b0001, 1'b1, 0, golden_int2float(11'(i % 2048)));
        end
        idle(3);
        check("count_fffe", {16'd0, conv_count}, 32'h0000FFFE);
        set_data(0, 11'd2047);
        step(4'b0001, 1'b1, 0, 7'h7F);
        idle(3);
        check("count_ffff", {16'd0, conv_count}, 32'h0000FFFF);
        set_data(0, 11'd16);
        step(4'b0001, 1'b1, 0, 7'h10);
        idle(3);
        check("count_wrap", {16'd0, conv_count}, 32'h00000000);

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
